// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the 19-bit CPU: fetch/decode/execute/mem/wb.
// Optional memory wait states are enabled by defining MC_WAIT_STATE_EN.
module multicycle_ctrl #(
   parameter int ADDR_W = 19
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] op,
   input  logic [4:0] funct5,
   input  logic       f7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       memwrite,
   output logic       irwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] immsrc,
   output logic       regwrite,
   output logic [3:0] alucontrol,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ITYPE = 5'b00001;
   localparam logic [4:0] OP_LOAD  = 5'b00010;
   localparam logic [4:0] OP_STORE = 5'b00011;
   localparam logic [4:0] OP_BEQ   = 5'b00100;
   localparam logic [4:0] OP_BNE   = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b00110;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;

   typedef struct packed {
      logic       pcupdate;
      logic       adrsrc;
      logic       memwrite;
      logic       irwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic       regwrite;
      logic [3:0] alucontrol;
   } ctl_t;

   // Moore output table; fctl is the funct-derived ALU code for EXECR/EXECI.
   function automatic ctl_t ctl_of(input state_t s, input logic [3:0] fctl);
      ctl_t c;
      c = '0;
      unique case (s)
         S_FETCH: begin
            c.irwrite   = 1'b1;
            c.alusrcb   = 2'b10;
            c.resultsrc = 2'b10;
            c.pcupdate  = 1'b1;
         end
         S_DECODE: begin
            c.alusrca = 2'b01;
            c.alusrcb = 2'b01;
         end
         S_MEMADR: begin
            c.alusrca = 2'b10;
            c.alusrcb = 2'b01;
         end
         S_MEMREAD: c.adrsrc = 1'b1;
         S_MEMWB: begin
            c.resultsrc = 2'b01;
            c.regwrite  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adrsrc   = 1'b1;
            c.memwrite = 1'b1;
         end
         S_EXECR: begin
            c.alusrca    = 2'b10;
            c.alucontrol = fctl;
         end
         S_EXECI: begin
            c.alusrca    = 2'b10;
            c.alusrcb    = 2'b01;
            c.alucontrol = fctl;
         end
         S_ALUWB: c.regwrite = 1'b1;
         S_BRANCH: begin
            c.alusrca    = 2'b10;
            c.alucontrol = ALU_SUB;
         end
         S_JAL: begin
            c.alusrca  = 2'b01;
            c.alusrcb  = 2'b10;
            c.pcupdate = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t     cur;
   state_t     nxt;
   ctl_t       ctl;
   logic       gate;
   logic       legal;
   logic       taken;
   logic [3:0] fctl;
   logic [31:0] aw;
   logic       unused_ok;

   assign aw        = ADDR_W;
   assign unused_ok = ^{mem_ready, aw, funct5[4:3]};

   // gate is low only while a memory-facing state waits for mem_ready.
`ifdef MC_WAIT_STATE_EN
   assign gate = mem_ready |
                 ~((cur == S_FETCH) | (cur == S_MEMREAD) |
                   (cur == S_MEMWRITE));
`else
   assign gate = 1'b1;
`endif

   assign legal = (op <= OP_JAL);
   assign taken = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
   assign fctl  = {f7b5 & (op == OP_RTYPE), funct5[2:0]};

   always_comb begin
      nxt = cur;
      unique case (cur)
         S_FETCH: if (gate) nxt = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_RTYPE:          nxt = S_EXECR;
               OP_ITYPE:          nxt = S_EXECI;
               OP_BEQ, OP_BNE:    nxt = S_BRANCH;
               OP_JAL:            nxt = S_JAL;
               default:           nxt = S_FETCH;
            endcase
         end
         S_MEMADR:
            nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (gate) nxt = S_MEMWB;
         S_MEMWB:    nxt = S_FETCH;
         S_MEMWRITE: if (gate) nxt = S_FETCH;
         S_EXECR:    nxt = S_ALUWB;
         S_EXECI:    nxt = S_ALUWB;
         S_ALUWB:    nxt = S_FETCH;
         S_BRANCH:   nxt = S_FETCH;
         S_JAL:      nxt = S_ALUWB;
         default:    nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur <= S_FETCH;
         ctl <= ctl_of(S_FETCH, ALU_ADD);
      end else begin
         cur <= nxt;
         ctl <= ctl_of(nxt, fctl);
      end
   end

   always_comb begin
      immsrc = 2'b00;
      unique case (1'b1)
         (op == OP_STORE):                  immsrc = 2'b01;
         (op == OP_BEQ) || (op == OP_BNE): immsrc = 2'b10;
         (op == OP_JAL):                    immsrc = 2'b11;
         default:                           immsrc = 2'b00;
      endcase
   end

   assign pcwrite    = (ctl.pcupdate & gate) |
                       ((cur == S_BRANCH) & taken);
   assign irwrite    = ctl.irwrite & gate;
   assign memwrite   = ctl.memwrite & gate;
   assign adrsrc     = ctl.adrsrc;
   assign resultsrc  = ctl.resultsrc;
   assign alusrca    = ctl.alusrca;
   assign alusrcb    = ctl.alusrcb;
   assign regwrite   = ctl.regwrite;
   assign alucontrol = ctl.alucontrol;
   assign illegal    = (cur == S_DECODE) & ~legal;
   assign state      = cur;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Sequencing controller for the multi-cycle build of the 19-bit CPU. One shared memory port, one ALU and the PC/IR/register-file enables are driven from a Moore-style FSM that steps each instruction through fetch, decode, execute, memory and writeback. It replaces the single-cycle decode path when the datapath is built with non-architectural IR/A/B/ALUOut/Data registers.

## Interface
Parameters
- ADDR_W, 19, address width (informational; the block carries no address state)

Ports
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- op  in  5  opcode field of IR
- funct5  in  5  function field of IR
- f7b5  in  1  ALU modifier bit of IR
- zero  in  1  ALU zero flag (valid in the BRANCH state)
- mem_ready  in  1  memory access complete (used only with MC_WAIT_STATE_EN)
- pcwrite  out  1  PC register enable
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR and OldPC enable
- resultsrc  out  2  00 ALUOut, 01 Data, 10 ALU result
- alusrca  out  2  00 PC, 01 OldPC, 10 A
- alusrcb  out  2  00 B, 01 ImmExt, 10 constant 1
- immsrc  out  2  00 I-form, 01 S-form, 10 B-form, 11 J-form
- regwrite  out  1  register file write enable
- alucontrol  out  4  ALU operation
- illegal  out  1  one-cycle pulse on an undefined opcode
- state  out  4  current FSM state (debug)

## Operation
Opcodes: RTYPE 00000, ITYPE 00001, LOAD 00010, STORE 00011, BEQ 00100, BNE 00101, JAL 00110. All others are illegal.

States and encodings:
- FETCH 0
- DECODE 1
- MEMADR 2
- MEMREAD 3
- MEMWB 4
- MEMWRITE 5
- EXECR 6
- EXECI 7
- ALUWB 8
- BRANCH 9
- JAL 10

State outputs and transitions:
- FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=add, resultsrc=10, pcupdate=1. Next state DECODE.
- DECODE: alusrca=01, alusrcb=01, aluop=add (branch/jump target into ALUOut).
  - LOAD/STORE → MEMADR
  - RTYPE → EXECR
  - ITYPE → EXECI
  - BEQ/BNE → BRANCH
  - JAL → JAL
  - illegal → FETCH, illegal=1 for that cycle
- MEMADR: alusrca=10, alusrcb=01, aluop=add. LOAD → MEMREAD; STORE → MEMWRITE.
- MEMREAD: resultsrc=00, adrsrc=1 → MEMWB.
- MEMWB: resultsrc=01, regwrite=1 → FETCH.
- MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1 → FETCH.
- EXECR: alusrca=10, alusrcb=00, aluop=funct → ALUWB.
- EXECI: alusrca=10, alusrcb=01, aluop=funct → ALUWB.
- ALUWB: resultsrc=00, regwrite=1 → FETCH.
- BRANCH: alusrca=10, alusrcb=00, aluop=sub, resultsrc=00. Branch taken when BEQ&zero or BNE&~zero. → FETCH.
- JAL: alusrca=01, alusrcb=10, aluop=add, resultsrc=00, pcupdate=1. Writes the link register through the ALUWB path. → ALUWB.

Signal rules:
- pcwrite = pcupdate | (branch taken in BRANCH).
- alucontrol: add → 0000; sub → 1000; funct → {f7b5 & (op==RTYPE), funct5[2:0]}.
- immsrc is decoded combinationally from op in every state:
  - STORE 01
  - BEQ/BNE 10
  - JAL 11
  - else 00
- Every output not listed for a state is 0.

## Timing
- Reset (rst_n=0, asynchronous): state=FETCH. In the cycle after reset release, FETCH drives irwrite=1, pcwrite=1. All other enables are 0 and illegal=0.
- Latency in cycles (no wait states): LOAD 5; RTYPE, ITYPE, STORE and JAL 4; BEQ/BNE 3; illegal 2.
- Outputs are decoded from state only (Moore). The exceptions are pcwrite in BRANCH (depends on zero) and immsrc (depends on op).
- When rst_n is asserted mid-instruction, the in-flight instruction is abandoned. No memwrite or regwrite is issued after rst_n falls.

## Configuration
- MC_WAIT_STATE_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold while mem_ready=0.
  - While holding, each state keeps its outputs asserted, except that irwrite, pcwrite and memwrite are gated by mem_ready. Each of these is therefore a single-cycle pulse in the cycle where mem_ready=1.
  - The state advances only when mem_ready=1.
- MC_WAIT_STATE_EN undefined: mem_ready is ignored and every state lasts exactly one cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → state=0, irwrite=1, pcwrite=1, regwrite=0, memwrite=0.
- RTYPE sub (op=00000, funct5=00000, f7b5=1) → states 0,1,6,8. alucontrol=1000 in EXECR; regwrite=1 only in cycle 4.
- LOAD (op=00010) → states 0,1,2,3,4; adrsrc=1 in MEMREAD; resultsrc=01 and regwrite=1 in MEMWB. STORE (00011) → 0,1,2,5 with memwrite=1 once and immsrc=01.
- BEQ with zero=1 → pcwrite=1 in BRANCH. BEQ with zero=0 → pcwrite=0. BNE with zero=0 → pcwrite=1. All take 3 cycles.
- Illegal op=11111 → illegal=1 for one cycle in DECODE, then FETCH; no regwrite or memwrite.
- With MC_WAIT_STATE_EN: LOAD with mem_ready=0 for 2 cycles in MEMREAD → state stays 3 for 3 cycles. Total latency 7; irwrite pulses once per fetch.
